// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// Programmable countdown timer. It loads a start value on a start request,
// counts down to zero and pulses done for one cycle. At the terminal count it
// either returns to idle (one-shot) or reloads and counts again (auto-reload).
// Pause freezes a running count. Abort drops back to idle without a done
// pulse. A saturating counter reports how many periods have completed since
// the last start.
//
// Parameters
//   WIDTH    : width of the count value (q, load_val)
//   PCNT_W   : width of the completed-period counter (periods)
//
// Ports
//   clk      in  : rising-edge clock
//   rst      in  : synchronous, active-high reset
//   start    in  : start request, only honoured while idle
//   load_val in  : count start value, captured together with start
//   mode     in  : 0 = one-shot, 1 = auto-reload; read at every terminal count
//   pause    in  : holds all state while running
//   abort    in  : forces idle, q cleared, no done pulse
//   q        out : current count value
//   ready    out : high while idle
//   busy     out : high while running (always the inverse of ready)
//   done     out : one-cycle pulse in the cycle q becomes 0
//   periods  out : completed periods since the last start, saturating
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH  = 5,
  parameter int PCNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              mode,
  input  logic              pause,
  input  logic              abort,
  output logic [WIDTH-1:0]  q,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [PCNT_W-1:0] periods
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [PCNT_W-1:0] PCNT_MAX = '1;
  localparam logic [WIDTH-1:0]  Q_ONE    = WIDTH'(1);

  state_t            state;
  state_t            state_next;
  logic [WIDTH-1:0]  q_next;
  logic [WIDTH-1:0]  reload;
  logic [WIDTH-1:0]  reload_next;
  logic              done_next;
  logic [PCNT_W-1:0] periods_next;
  logic [PCNT_W-1:0] periods_inc;

  // The period counter sticks at all-ones instead of wrapping.
  assign periods_inc = (periods == PCNT_MAX) ? periods : periods + PCNT_W'(1);

  // ready/busy decode straight from the state flop, so they are registered.
  assign ready = (state == IDLE);
  assign busy  = (state == RUN);

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // one unassigned; an unassigned path would infer a latch.
    state_next   = state;
    q_next       = q;
    reload_next  = reload;
    periods_next = periods;
    done_next    = 1'b0;

    if (abort) begin
      // Abort wins over pause; periods keeps its value.
      state_next = IDLE;
      q_next     = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_next  = RUN;
            q_next      = load_val;
            reload_next = load_val;
            if (load_val == '0) begin
              // A zero load reaches its terminal count immediately.
              done_next    = 1'b1;
              periods_next = PCNT_W'(1);
            end else begin
              periods_next = '0;
            end
          end
        end

        RUN: begin
          if (!pause) begin
            if (q != '0) begin
              q_next = q - Q_ONE;
              if (q == Q_ONE) begin
                done_next    = 1'b1;
                periods_next = periods_inc;
              end
            end else if (mode) begin
              // Terminal cycle, auto-reload. A zero reload value lands on
              // zero again, so it completes a period every cycle.
              q_next = reload;
              if (reload == '0) begin
                done_next    = 1'b1;
                periods_next = periods_inc;
              end
            end else begin
              // Terminal cycle, one-shot: q is already 0 and stays there.
              state_next = IDLE;
            end
          end
          // A paused terminal cycle simply waits here; done stays low.
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (rst) begin
      state   <= IDLE;
      q       <= '0;
      reload  <= '0;
      done    <= 1'b0;
      periods <= '0;
    end else begin
      state   <= state_next;
      q       <= q_next;
      reload  <= reload_next;
      done    <= done_next;
      periods <= periods_next;
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Scoreboard bench for countdown_timer. A driver applies directed and random
// stimulus on the falling edge, steps an arithmetic reference model and pushes
// the expected outputs for the next rising edge into a queue. An independent
// monitor samples the DUT after each rising edge and compares against the
// head of the queue.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int WIDTH  = 5;
  localparam int PCNT_W = 4;
  localparam int PMAX   = (1 << PCNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [WIDTH-1:0]  load_val;
  logic              mode;
  logic              pause;
  logic              abort;
  logic [WIDTH-1:0]  q;
  logic              ready;
  logic              busy;
  logic              done;
  logic [PCNT_W-1:0] periods;

  countdown_timer #(
    .WIDTH (WIDTH),
    .PCNT_W(PCNT_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .load_val(load_val),
    .mode    (mode),
    .pause   (pause),
    .abort   (abort),
    .q       (q),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .periods (periods)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    bit ready;
    bit busy;
    bit done;
    int periods;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a running flag, the remaining count, the reload value and
  // the completed-period count, all as plain integers.
  // ---------------------------------------------------------------------------
  bit m_run = 0;
  int m_q   = 0;
  int m_rel = 0;
  int m_per = 0;

  function automatic int sat_inc(input int v);
    return (v + 1 > PMAX) ? PMAX : v + 1;
  endfunction

  task automatic model_step(input bit r, input bit s, input int lv,
                            input bit md, input bit p, input bit a);
    exp_t e;
    bit   d;
    d = 0;
    if (r) begin
      m_run = 0; m_q = 0; m_rel = 0; m_per = 0;
    end else if (a) begin
      m_run = 0; m_q = 0;
    end else if (!m_run) begin
      if (s) begin
        m_run = 1; m_rel = lv; m_q = lv; m_per = 0;
        if (lv == 0) begin d = 1; m_per = 1; end
      end
    end else if (!p) begin
      if (m_q > 0) begin
        m_q = m_q - 1;
        if (m_q == 0) begin d = 1; m_per = sat_inc(m_per); end
      end else if (md) begin
        m_q = m_rel;
        if (m_rel == 0) begin d = 1; m_per = sat_inc(m_per); end
      end else begin
        m_run = 0;
      end
    end
    e.q       = m_q;
    e.ready   = !m_run;
    e.busy    = m_run;
    e.done    = d;
    e.periods = m_per;
    sb.push_back(e);
  endtask

  // One clock of stimulus: drive on the falling edge, predict the next edge.
  task automatic cyc(input bit r, input bit s, input int lv,
                     input bit md, input bit p, input bit a);
    logic [31:0] lv_bits;
    @(negedge clk);
    lv_bits  = lv;
    rst      = r;
    start    = s;
    load_val = lv_bits[WIDTH-1:0];
    mode     = md;
    pause    = p;
    abort    = a;
    model_step(r, s, lv, md, p, a);
  endtask

  // Idle-input cycles until the model count equals target (bounded).
  task automatic run_until_q(input int target, input bit md, input int limit,
                             input string tag);
    int n;
    n = 0;
    while (m_q != target && n < limit) begin
      cyc(0, 0, 0, md, 0, 0);
      n++;
    end
    if (m_q != target) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: model q=%0d required %0d", tag, m_q, target);
    end
  endtask

  task automatic idle_cycles(input int n, input bit md);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, md, 0, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: the DUT presents a full output set after every rising edge.
  // ---------------------------------------------------------------------------
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (int'(q) != e.q || ready !== e.ready || busy !== e.busy ||
            done !== e.done || int'(periods) != e.periods) begin
          errors++;
          $display("FAIL outputs t=%0t got q=%0d ready=%b busy=%b done=%b periods=%0d required q=%0d ready=%b busy=%b done=%b periods=%0d",
                   $time, q, ready, busy, done, periods,
                   e.q, e.ready, e.busy, e.done, e.periods);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  initial begin : driver
    bit r, s, md, p, a;
    int lv;

    rst = 1'b1; start = 1'b0; load_val = '0;
    mode = 1'b0; pause = 1'b0; abort = 1'b0;

    // Reset held two cycles with start asserted.
    cyc(1, 1, 9, 0, 0, 0);
    cyc(1, 1, 9, 0, 0, 0);

    // One-shot from 31, then start held high through a count and beyond.
    cyc(0, 1, 31, 0, 0, 0);
    idle_cycles(34, 0);
    for (int i = 0; i < 40; i++) cyc(0, 1, 31, 0, 0, 0);
    idle_cycles(36, 0);

    // Auto-reload from 3 long enough for periods to saturate.
    cyc(0, 1, 3, 1, 0, 0);
    idle_cycles(70, 1);
    cyc(0, 0, 0, 1, 0, 1);

    // Pause three cycles while q is 2.
    cyc(0, 1, 5, 0, 0, 0);
    run_until_q(2, 0, 10, "pause_setup");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
    idle_cycles(6, 0);

    // Zero load, one-shot.
    cyc(0, 1, 0, 0, 0, 0);
    idle_cycles(3, 0);

    // Zero load, auto-reload (done every cycle), then mode dropped.
    cyc(0, 1, 0, 1, 0, 0);
    idle_cycles(5, 1);
    idle_cycles(3, 0);

    // Auto-reload from 2, mode dropped during a terminal cycle.
    cyc(0, 1, 2, 1, 0, 0);
    idle_cycles(4, 1);
    run_until_q(0, 1, 10, "terminal_setup");
    idle_cycles(4, 0);

    // Paused terminal cycle in auto-reload: no second done.
    cyc(0, 1, 1, 1, 0, 0);
    idle_cycles(1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 1, 0);
    idle_cycles(3, 1);
    cyc(0, 0, 0, 1, 0, 1);

    // Abort at q=7, together with pause.
    cyc(0, 1, 20, 0, 0, 0);
    run_until_q(7, 0, 30, "abort_setup");
    cyc(0, 0, 0, 0, 1, 1);
    idle_cycles(2, 0);

    // Reset at q=10 in auto-reload, after a completed period.
    cyc(0, 1, 12, 1, 0, 0);
    idle_cycles(14, 1);
    run_until_q(10, 1, 30, "reset_setup");
    cyc(1, 1, 4, 1, 1, 1);
    idle_cycles(2, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      a  = ($urandom_range(0, 39) == 0);
      p  = ($urandom_range(0, 4) == 0);
      s  = ($urandom_range(0, 2) == 0);
      md = ($urandom_range(0, 1) == 1);
      lv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2))
                                       : int'($urandom_range(0, 31));
      cyc(r, s, lv, md, p, a);
    end

    // Drain the scoreboard.
    @(posedge clk);
    #3;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
